// File: rtl/Falco_pkg.sv
// Shared types and sizing for the store data buffer and its drain unit.
package Falco_pkg;

  localparam int SDB_NUM    = 16;
  localparam int SDB_WIDTH  = $clog2(SDB_NUM);
  localparam int ENTRY_XLEN = 32;

  // Payload carried from an SDB entry to the data cache.
  typedef struct packed {
    logic [ENTRY_XLEN-1:0]   addr;
    logic [ENTRY_XLEN-1:0]   data;
    logic [ENTRY_XLEN/8-1:0] be;
  } sdb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    POP  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/sdb_drain_unit.sv
// Retires the oldest committed SDB entry to the data cache, one write at a
// time, then pops it. While a write is in flight the entry index is exported
// so the push side never combines new bytes into an entry that is leaving.
// XLEN must match the package entry width, since the payload register is a
// single sdb_entry_t.
module sdb_drain_unit #(
  parameter int SDB_WIDTH = Falco_pkg::SDB_WIDTH,
  parameter int XLEN      = Falco_pkg::ENTRY_XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 head_valid_i,
  input  logic                 head_committed_i,
  input  logic [SDB_WIDTH-1:0] head_index_i,
  input  logic [XLEN-1:0]      head_addr_i,
  input  logic [XLEN-1:0]      head_data_i,
  input  logic [XLEN/8-1:0]    head_be_i,
  output logic                 mem_req_o,
  output logic [XLEN-1:0]      mem_addr_o,
  output logic [XLEN-1:0]      mem_wdata_o,
  output logic [XLEN/8-1:0]    mem_be_o,
  input  logic                 mem_ready_i,
  input  logic                 mem_done_i,
  output logic                 pop_o,
  output logic [SDB_WIDTH-1:0] pop_index_o,
  output logic                 inflight_valid_o,
  output logic [SDB_WIDTH-1:0] inflight_index_o,
  input  logic                 fence_i,
  output logic                 drained_o,
  output logic [31:0]          drained_count_o
);

  import Falco_pkg::*;

  drain_state_t         state_q;
  drain_state_t         state_d;
  sdb_entry_t           payload_q;
  logic [SDB_WIDTH-1:0] index_q;
  logic                 inflight_q;
  logic [31:0]          drained_count_q;
  logic                 head_eligible;
  logic                 launch;

  // Only a committed head may leave; an uncommitted head blocks everything
  // behind it, fence or not.
  assign head_eligible = head_valid_i && head_committed_i;
  assign launch        = (state_q == IDLE) && head_eligible;

  // State register; reset abandons any write in flight without popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus state-decoded outputs, so pop_o and mem_req_o carry no
  // combinational path from the mem_* handshake inputs.
  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    pop_o       = 1'b0;
    pop_index_o = '0;
    unique case (state_q)
      IDLE: begin
        if (head_eligible) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          state_d = mem_done_i ? POP : WAIT;
        end
      end
      WAIT: begin
        if (mem_done_i) begin
          state_d = POP;
        end
      end
      POP: begin
        pop_o       = 1'b1;
        pop_index_o = index_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Head inputs are captured only when leaving IDLE; the payload then stays
  // frozen for the whole write regardless of what the SDB head does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_q <= '0;
      index_q   <= '0;
    end else if (launch) begin
      payload_q.addr <= head_addr_i;
      payload_q.data <= head_data_i;
      payload_q.be   <= head_be_i;
      index_q        <= head_index_i;
    end
  end

  // In-flight flag covers REQ through POP inclusive for combine exclusion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else if (launch) begin
      inflight_q <= 1'b1;
    end else if (state_q == POP) begin
      inflight_q <= 1'b0;
    end
  end

  // Retired-store counter, bumped once per pop and free to wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drained_count_q <= '0;
    end else if (state_q == POP) begin
      drained_count_q <= drained_count_q + 32'd1;
    end
  end

  assign mem_addr_o       = payload_q.addr;
  assign mem_wdata_o      = payload_q.data;
  assign mem_be_o         = payload_q.be;
  assign inflight_valid_o = inflight_q;
  assign inflight_index_o = index_q;
  assign drained_count_o  = drained_count_q;

  // Fence completion: nothing in flight and nothing left at the head.
  assign drained_o = fence_i && (state_q == IDLE) && !head_valid_i;

endmodule

// File: tb/tb_sdb_drain_unit.sv
// Scoreboard bench for sdb_drain_unit: a small SDB model feeds the head,
// expected writes/pops are queued as stores are injected and compared when
// the drain unit produces them.
module tb_sdb_drain_unit;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        committed;
  } ent_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        head_valid_i = 1'b0;
  logic        head_committed_i = 1'b0;
  logic [3:0]  head_index_i = '0;
  logic [31:0] head_addr_i = '0;
  logic [31:0] head_data_i = '0;
  logic [3:0]  head_be_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i = 1'b0;
  logic        mem_done_i = 1'b0;
  logic        pop_o;
  logic [3:0]  pop_index_o;
  logic        inflight_valid_o;
  logic [3:0]  inflight_index_o;
  logic        fence_i = 1'b0;
  logic        drained_o;
  logic [31:0] drained_count_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_count = '0;

  ent_t       sdb_q[$];
  wr_t        exp_q[$];
  wr_t        wr_obs_q[$];
  logic [3:0] pop_idx_q[$];
  int         pop_cyc_q[$];
  int         req_cyc_q[$];

  sdb_drain_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .head_valid_i     (head_valid_i),
    .head_committed_i (head_committed_i),
    .head_index_i     (head_index_i),
    .head_addr_i      (head_addr_i),
    .head_data_i      (head_data_i),
    .head_be_i        (head_be_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_be_o         (mem_be_o),
    .mem_ready_i      (mem_ready_i),
    .mem_done_i       (mem_done_i),
    .pop_o            (pop_o),
    .pop_index_o      (pop_index_o),
    .inflight_valid_o (inflight_valid_o),
    .inflight_index_o (inflight_index_o),
    .fence_i          (fence_i),
    .drained_o        (drained_o),
    .drained_count_o  (drained_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and SDB model: record DUT activity at the falling edge, retire
  // the SDB head on a pop, then present the new head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_o) req_cyc_q.push_back(cyc);
      if (mem_req_o && mem_ready_i)
        wr_obs_q.push_back({inflight_index_o, mem_addr_o, mem_wdata_o, mem_be_o});
      if (pop_o) begin
        pop_idx_q.push_back(pop_index_o);
        pop_cyc_q.push_back(cyc);
        if (sdb_q.size() > 0) sdb_q.delete(0);
      end
    end
    if (sdb_q.size() > 0) begin
      head_valid_i     = 1'b1;
      head_committed_i = sdb_q[0].committed;
      head_index_i     = sdb_q[0].idx;
      head_addr_i      = sdb_q[0].addr;
      head_data_i      = sdb_q[0].data;
      head_be_i        = sdb_q[0].be;
    end else begin
      head_valid_i     = 1'b0;
      head_committed_i = 1'b0;
      head_index_i     = '0;
      head_addr_i      = '0;
      head_data_i      = '0;
      head_be_i        = '0;
    end
  end

  task automatic clear_obs();
    wr_obs_q.delete();
    pop_idx_q.delete();
    pop_cyc_q.delete();
    req_cyc_q.delete();
  endtask

  task automatic add_store(input logic [3:0] idx, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           input logic committed);
    sdb_q.push_back({idx, addr, data, be, committed});
    exp_q.push_back({idx, addr, data, be});
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (pop_idx_q.size() >= n) break;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_req_o, pop_o, inflight_valid_o, drained_o} !== 4'b0000)
      $display("[TB] FAIL reset_ctrl: got %b want 0000", {mem_req_o, pop_o, inflight_valid_o, drained_o});
    checks++;
    if ({mem_addr_o, mem_wdata_o, mem_be_o, pop_index_o, inflight_index_o} !== '0)
      $display("[TB] FAIL reset_payload: got %h/%h/%h/%h/%h want all 0", mem_addr_o, mem_wdata_o, mem_be_o, pop_index_o, inflight_index_o);
    checks++;
    if (drained_count_o !== 32'd0)
      $display("[TB] FAIL reset_count: got %0d want 0", drained_count_o);
    errors += int'({mem_req_o, pop_o, inflight_valid_o, drained_o} !== 4'b0000)
            + int'({mem_addr_o, mem_wdata_o, mem_be_o, pop_index_o, inflight_index_o} !== '0)
            + int'(drained_count_o !== 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || inflight_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: req=%b inflight=%b want 0/0", mem_req_o, inflight_valid_o);
    end
  endtask

  task automatic test_single_store();
    wr_t e;
    clear_obs();
    mem_ready_i = 1'b1;
    mem_done_i  = 1'b1;
    add_store(4'd3, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1'b1);
    exp_count++;
    wait_pops(1, 20);
    checks++;
    if (pop_idx_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL single_pops: got %0d pops want 1", pop_idx_q.size());
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (pop_idx_q[0] !== e.idx) begin
      errors++;
      $display("[TB] FAIL single_pop_index: got %0d want %0d", pop_idx_q[0], e.idx);
    end
    checks++;
    if (wr_obs_q.size() !== 1 || wr_obs_q[0] !== e) begin
      errors++;
      $display("[TB] FAIL single_write: got %0d writes, first %h want %h", wr_obs_q.size(), (wr_obs_q.size() > 0) ? wr_obs_q[0] : '0, e);
    end
    checks++;
    if (req_cyc_q.size() !== 1 || pop_cyc_q[0] - req_cyc_q[0] !== 1) begin
      errors++;
      $display("[TB] FAIL single_latency: req cycles %0d, pop-req gap %0d want 1/1", req_cyc_q.size(), (req_cyc_q.size() > 0) ? pop_cyc_q[0] - req_cyc_q[0] : -1);
    end
    checks++;
    if (drained_count_o !== exp_count) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d want %0d", drained_count_o, exp_count);
    end
  endtask

  task automatic test_backpressure();
    wr_t e;
    int  n;
    clear_obs();
    mem_ready_i = 1'b0;
    mem_done_i  = 1'b0;
    add_store(4'd9, 32'h8000_2040, 32'h1234_5678, 4'b0110, 1'b1);
    e = exp_q[0];
    for (int k = 0; k < 20 && req_cyc_q.size() == 0; k++) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (mem_req_o !== 1'b1 || {inflight_index_o, mem_addr_o, mem_wdata_o, mem_be_o} !== e || pop_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: req=%b pop=%b payload=%h want 1/0/%h", i, mem_req_o, pop_o, {inflight_index_o, mem_addr_o, mem_wdata_o, mem_be_o}, e);
      end
      @(posedge clk);
    end
    #1 mem_ready_i = 1'b1;
    @(posedge clk);
    #1 mem_ready_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0 || pop_o !== 1'b0 || inflight_valid_o !== 1'b1 || inflight_index_o !== 4'd9) begin
      errors++;
      $display("[TB] FAIL bp_wait: req=%b pop=%b inflight=%b/%0d want 0/0/1/9", mem_req_o, pop_o, inflight_valid_o, inflight_index_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pop_o !== 1'b0 || inflight_index_o !== 4'd9) begin
      errors++;
      $display("[TB] FAIL bp_no_early_pop: pop=%b idx=%0d want 0/9", pop_o, inflight_index_o);
    end
    mem_done_i = 1'b1;
    @(posedge clk);
    #1 mem_done_i = 1'b0;
    checks++;
    if (pop_o !== 1'b1 || pop_index_o !== 4'd9 || inflight_index_o !== 4'd9) begin
      errors++;
      $display("[TB] FAIL bp_pop: pop=%b idx=%0d inflight_idx=%0d want 1/9/9", pop_o, pop_index_o, inflight_index_o);
    end
    exp_count++;
    repeat (3) @(posedge clk);
    #1;
    void'(exp_q.pop_front());
    n = pop_idx_q.size();
    checks++;
    if (n !== 1 || wr_obs_q.size() !== 1 || drained_count_o !== exp_count) begin
      errors++;
      $display("[TB] FAIL bp_totals: pops=%0d writes=%0d count=%0d want 1/1/%0d", n, wr_obs_q.size(), drained_count_o, exp_count);
    end
    mem_ready_i = 1'b1;
    mem_done_i  = 1'b1;
  endtask

  task automatic test_uncommitted();
    wr_t e;
    clear_obs();
    mem_ready_i = 1'b1;
    mem_done_i  = 1'b1;
    fence_i     = 1'b1;
    add_store(4'd7, 32'h8000_3000, 32'hCAFE_F00D, 4'b0011, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (req_cyc_q.size() !== 0 || drained_o !== 1'b0 || inflight_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL uncommitted_block: reqs=%0d drained=%b inflight=%b want 0/0/0", req_cyc_q.size(), drained_o, inflight_valid_o);
    end
    sdb_q[0].committed = 1'b1;
    exp_count++;
    wait_pops(1, 20);
    e = exp_q.pop_front();
    checks++;
    if (pop_idx_q.size() !== 1 || pop_idx_q[0] !== e.idx || wr_obs_q.size() !== 1 || wr_obs_q[0] !== e) begin
      errors++;
      $display("[TB] FAIL uncommitted_drain: pops=%0d writes=%0d want 1 pop of idx %0d", pop_idx_q.size(), wr_obs_q.size(), e.idx);
    end
    checks++;
    if (drained_o !== 1'b1 || drained_count_o !== exp_count) begin
      errors++;
      $display("[TB] FAIL fence_drained: drained=%b count=%0d want 1/%0d", drained_o, drained_count_o, exp_count);
    end
    fence_i = 1'b0;
    #1;
    checks++;
    if (drained_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fence_low: drained=%b want 0", drained_o);
    end
  endtask

  task automatic test_back_to_back();
    wr_t e;
    clear_obs();
    mem_ready_i = 1'b1;
    mem_done_i  = 1'b1;
    add_store(4'd14, 32'h8000_4000, 32'h0000_0011, 4'b0001, 1'b1);
    add_store(4'd15, 32'h8000_4004, 32'h0000_2200, 4'b0010, 1'b1);
    add_store(4'd0,  32'h8000_4008, 32'h0033_0000, 4'b0100, 1'b1);
    add_store(4'd1,  32'h8000_400C, 32'h4400_0000, 4'b1000, 1'b1);
    exp_count += 4;
    wait_pops(4, 60);
    checks++;
    if (pop_idx_q.size() !== 4 || wr_obs_q.size() !== 4) begin
      errors++;
      $display("[TB] FAIL stream_count: pops=%0d writes=%0d want 4/4", pop_idx_q.size(), wr_obs_q.size());
      return;
    end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (pop_idx_q[i] !== e.idx || wr_obs_q[i] !== e) begin
        errors++;
        $display("[TB] FAIL stream_entry_%0d: idx=%0d write=%h want %0d/%h", i, pop_idx_q[i], wr_obs_q[i], e.idx, e);
      end
      if (i > 0) begin
        checks++;
        if (pop_cyc_q[i] - pop_cyc_q[i-1] !== 3) begin
          errors++;
          $display("[TB] FAIL stream_gap_%0d: got %0d cycles want 3", i, pop_cyc_q[i] - pop_cyc_q[i-1]);
        end
      end
    end
    checks++;
    if (drained_count_o !== exp_count) begin
      errors++;
      $display("[TB] FAIL stream_total: got %0d want %0d", drained_count_o, exp_count);
    end
  endtask

  task automatic test_reset_midflight();
    wr_t e;
    clear_obs();
    mem_ready_i = 1'b1;
    mem_done_i  = 1'b0;
    add_store(4'd5, 32'h8000_5000, 32'hA5A5_5A5A, 4'b1111, 1'b1);
    for (int k = 0; k < 20 && req_cyc_q.size() == 0; k++) @(posedge clk);
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || inflight_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_wait: req=%b inflight=%b want 0/1", mem_req_o, inflight_valid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, pop_o, inflight_valid_o, inflight_index_o, mem_addr_o, drained_count_o} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: req=%b pop=%b inflight=%b/%0d addr=%h count=%0d want all 0", mem_req_o, pop_o, inflight_valid_o, inflight_index_o, mem_addr_o, drained_count_o);
    end
    exp_count = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_done_i = 1'b1;
    checks++;
    if (pop_idx_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL reset_no_pop: got %0d pops want 0", pop_idx_q.size());
    end
    wr_obs_q.delete();
    exp_count++;
    wait_pops(1, 20);
    e = exp_q.pop_front();
    checks++;
    if (pop_idx_q.size() !== 1 || pop_idx_q[0] !== e.idx || wr_obs_q.size() !== 1 || wr_obs_q[0] !== e || drained_count_o !== exp_count) begin
      errors++;
      $display("[TB] FAIL redrain: pops=%0d writes=%0d count=%0d want 1 pop of idx %0d, count %0d", pop_idx_q.size(), wr_obs_q.size(), drained_count_o, e.idx, exp_count);
    end
  endtask

  task automatic test_counter_wrap();
    clear_obs();
    mem_ready_i = 1'b1;
    mem_done_i  = 1'b1;
    @(posedge clk);
    #1 force dut.drained_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.drained_count_q;
    exp_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    checks++;
    if (drained_count_o !== exp_count) begin
      errors++;
      $display("[TB] FAIL wrap_preload: got %h want %h", drained_count_o, exp_count);
    end
    add_store(4'd2, 32'h8000_6000, 32'h0BAD_F00D, 4'b1100, 1'b1);
    exp_count++;
    wait_pops(1, 20);
    void'(exp_q.pop_front());
    checks++;
    if (pop_idx_q.size() !== 1 || drained_count_o !== exp_count) begin
      errors++;
      $display("[TB] FAIL wrap_count: pops=%0d count=%h want 1/%h", pop_idx_q.size(), drained_count_o, exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_backpressure();
    test_uncommitted();
    test_back_to_back();
    test_reset_midflight();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sdb_drain_unit.md
# sdb_drain_unit

Read-side companion of the store data buffer (SDB). It retires the oldest committed SDB entry to the data cache with a request/ready/done handshake, then pops that entry. While a write is in flight, it exports the entry index so the push-side combining logic never merges new store bytes into an entry that is already leaving. It also provides a fence-drain indication and a retired-store counter.

## Interface
Parameters:
- SDB_NUM, 16 (Falco_pkg): number of SDB entries; power of two.
- SDB_WIDTH, 4 (Falco_pkg): index width, log2(SDB_NUM).
- XLEN, 32: address and data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- head_valid_i  in  1  SDB pop-head entry is valid
- head_committed_i  in  1  head entry's store has committed
- head_index_i  in  SDB_WIDTH  index of the pop-head entry
- head_addr_i  in  XLEN  word-aligned address of head entry
- head_data_i  in  XLEN  combined store data
- head_be_i  in  XLEN/8  byte enables
- mem_req_o  out  1  write request valid
- mem_addr_o / mem_wdata_o / mem_be_o  out  XLEN / XLEN / XLEN/8  write payload
- mem_ready_i  in  1  D-cache accepts request this cycle
- mem_done_i  in  1  accepted write has completed
- pop_o  out  1  one-cycle pulse: SDB advances pop head
- pop_index_o  out  SDB_WIDTH  index being popped
- inflight_valid_o  out  1  an entry is latched for draining
- inflight_index_o  out  SDB_WIDTH  that entry's index (combine exclusion)
- fence_i  in  1  level: request full drain
- drained_o  out  1  fence_i && IDLE && !head_valid_i
- drained_count_o  out  32  number of retired stores, wraps

## Operation
- FSM states: IDLE, REQ, WAIT, POP.
- IDLE: if head_valid_i && head_committed_i, latch index/addr/data/be into payload registers, set inflight_valid_o, -> REQ. Otherwise stay in IDLE.
- REQ: mem_req_o=1 with payload held stable until mem_ready_i.
  - ready && !done -> WAIT.
  - ready && done in the same cycle -> POP.
- WAIT: hold until mem_done_i, then -> POP. mem_req_o=0.
- POP: pop_o=1, pop_index_o = latched index, drained_count_o++ (mod 2^32), clear inflight_valid_o, -> IDLE.
- One write outstanding at most. Entries drain strictly in pop-head order.
- Uncommitted head entries are never drained. An uncommitted head blocks the drain, even with fence_i set.
- Head inputs are sampled only in IDLE. Changes in other states are ignored.
- mem_done_i outside REQ/WAIT is ignored. mem_ready_i outside REQ is ignored.
- fence_i does not alter draining. It only qualifies drained_o, which is combinational.

## Timing
- Reset values: state IDLE; all outputs 0; payload registers 0; drained_count_o 0.
- Reset asserted mid-transaction abandons the write; nothing is popped. The D-cache is reset in the same domain.
- Latency: eligible head seen in IDLE at cycle t -> mem_req_o at t+1.
  - Best case: ready and done both at t+1 -> pop_o at t+2.
  - Ready at t+1, done at t+2 -> pop_o at t+3.
- Re-evaluation: the cycle after POP is IDLE, which samples the new head. Back-to-back best-case throughput is one store per 3 cycles.
- inflight_valid_o and inflight_index_o are registered. They are valid from REQ through POP inclusive.
- pop_o is registered (a state decode), with no combinational path from mem_* inputs.
- drained_o depends combinationally on fence_i and head_valid_i only.

## Structure
- Falco_pkg holds:
  - SDB_NUM and SDB_WIDTH;
  - the sdb_entry_t struct {addr, data, be};
  - the drain_state_t enum {IDLE, REQ, WAIT, POP}.
- Single module with no sub-modules.
- Payload is latched as one sdb_entry_t register.

## Test plan
- Single store: head idx 3, committed, addr 0x80001000, data 0xDEADBEEF, be 0xF; ready and done at t+1 -> mem_req_o at t+1 only, pop_o at t+2 with pop_index_o=3, drained_count_o=1.
- Backpressure: ready low for 4 cycles, done 2 cycles after ready -> payload stable throughout REQ, no pop before done, one pop total, inflight_index_o constant.
- Uncommitted head: valid=1, committed=0 for 10 cycles, fence_i=1 -> no mem_req_o, drained_o=0; committed rises -> normal drain; drained_o=1 once head_valid_i=0.
- Stream of 4 entries idx 14,15,0,1 (wrap) with immediate ready/done -> pops in that order, 3 cycles apart, count=4.
- rst_n low during WAIT -> all outputs 0 immediately (asynchronous), no pop_o; after release the same head is re-drained from IDLE.
- Counter wrap: preload via 2^32-1 drains (forced) -> next pop gives drained_count_o=0.
